// File: rtl/sys_ctrl_rx_cmd_if.sv
// Bus between the UART-side command decoder and its neighbours.
// Carries UART RX bytes, register-file access and the UART TX handshake.
interface sys_ctrl_rx_cmd_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic                  i_rx_valid;
  logic                  o_en_w;
  logic                  o_en_r;
  logic [ADDR_WIDTH-1:0] o_add;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic [DATA_WIDTH-1:0] i_rd_data;
  logic                  i_rd_valid;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;
  logic                  o_busy;
  logic                  o_drop;

  modport master (
    input  i_rx_data, i_rx_valid,
    input  i_rd_data, i_rd_valid,
    input  i_tx_ready,
    output o_en_w, o_en_r, o_add, o_wr_data,
    output o_tx_data, o_tx_valid,
    output o_busy, o_drop
  );

  modport slave (
    output i_rx_data, i_rx_valid,
    output i_rd_data, i_rd_valid,
    output i_tx_ready,
    input  o_en_w, o_en_r, o_add, o_wr_data,
    input  o_tx_data, o_tx_valid,
    input  o_busy, o_drop
  );
endinterface

// File: rtl/sys_ctrl_rx_cmd.sv
// UART command decoder: frames AA,addr,data (write) / BB,addr (read).
// Ports: i_clk, i_rst (async low), bus (master). Opt: SYS_CTRL_TIMEOUT_EN.
module sys_ctrl_rx_cmd #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_WR         = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RD         = 8'hBB,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sys_ctrl_rx_cmd_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_EXEC,
    RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DATA_WIDTH-1:0] data, data_n;
  logic [DATA_WIDTH-1:0] tx_data_n;
  logic                  drop_n;
  logic                  tmo;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  logic          waiting;

  assign waiting = (state == WR_ADDR) ||
                   (state == WR_DATA) ||
                   (state == RD_ADDR);
  assign tmo = waiting && !bus.i_rx_valid &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (!waiting || bus.i_rx_valid || tmo) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      addr  <= '0;
      data  <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      data  <= data_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    data_n    = data;
    tx_data_n = bus.o_tx_data;
    drop_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_rx_valid) begin
          unique case (1'b1)
            bus.i_rx_data == CMD_WR: state_n = WR_ADDR;
            bus.i_rx_data == CMD_RD: state_n = RD_ADDR;
            default:                 drop_n  = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (bus.i_rx_valid) begin
          addr_n  = bus.i_rx_data[ADDR_WIDTH-1:0];
          state_n = WR_DATA;
        end else if (tmo) begin
          state_n = IDLE;
          drop_n  = 1'b1;
        end
      end
      WR_DATA: begin
        if (bus.i_rx_valid) begin
          data_n  = bus.i_rx_data;
          state_n = WR_EXEC;
        end else if (tmo) begin
          state_n = IDLE;
          drop_n  = 1'b1;
        end
      end
      RD_ADDR: begin
        if (bus.i_rx_valid) begin
          addr_n  = bus.i_rx_data[ADDR_WIDTH-1:0];
          state_n = RD_EXEC;
        end else if (tmo) begin
          state_n = IDLE;
          drop_n  = 1'b1;
        end
      end
      WR_EXEC: begin
        state_n = IDLE;
        drop_n  = bus.i_rx_valid;
      end
      RD_EXEC: begin
        state_n = RD_WAIT;
        drop_n  = bus.i_rx_valid;
      end
      RD_WAIT: begin
        drop_n = bus.i_rx_valid;
        if (bus.i_rd_valid) begin
          tx_data_n = bus.i_rd_data;
          state_n   = TX_SEND;
        end
      end
      TX_SEND: begin
        drop_n = bus.i_rx_valid;
        if (bus.i_tx_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bus.o_en_w     <= 1'b0;
      bus.o_en_r     <= 1'b0;
      bus.o_add      <= '0;
      bus.o_wr_data  <= '0;
      bus.o_tx_data  <= '0;
      bus.o_tx_valid <= 1'b0;
      bus.o_busy     <= 1'b0;
      bus.o_drop     <= 1'b0;
    end else begin
      bus.o_en_w     <= (state_n == WR_EXEC);
      bus.o_en_r     <= (state_n == RD_EXEC);
      bus.o_tx_data  <= tx_data_n;
      bus.o_tx_valid <= (state_n == TX_SEND);
      bus.o_busy     <= (state_n != IDLE);
      bus.o_drop     <= drop_n;
      if (state_n == WR_EXEC) begin
        bus.o_add     <= addr_n;
        bus.o_wr_data <= data_n;
      end
      if (state_n == RD_EXEC) begin
        bus.o_add <= addr_n;
      end
    end
  end

endmodule

// File: doc/sys_ctrl_rx_cmd.md
Name: sys_ctrl_rx_cmd

Overview:
Command decoder between the UART receiver and the system register file. It parses byte frames from UART RX into register-file write and read transactions. For reads, it returns the read data to the UART transmitter over a valid/ready handshake. It is the sole master of the register file's write/read enables, address and write-data inputs.

Parameters:
DATA_WIDTH, 8, width of UART bytes and register-file words
ADDR_WIDTH, 4, register-file address width; the address byte is truncated to its low ADDR_WIDTH bits
CMD_WR, 8'hAA, opcode for a write frame: CMD_WR, addr, data
CMD_RD, 8'hBB, opcode for a read frame: CMD_RD, addr
TIMEOUT_CYCLES, 1024, inter-byte timeout; used only with SYS_CTRL_TIMEOUT_EN

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-low reset
i_rx_data  in  DATA_WIDTH  received UART byte
i_rx_valid  in  1  single-cycle strobe; i_rx_data is valid this cycle
o_en_w  out  1  register-file write enable, one-cycle pulse
o_en_r  out  1  register-file read enable, one-cycle pulse
o_add  out  ADDR_WIDTH  register-file address
o_wr_data  out  DATA_WIDTH  register-file write data
i_rd_data  in  DATA_WIDTH  register-file read data
i_rd_valid  in  1  register-file read-data valid
o_tx_data  out  DATA_WIDTH  byte to UART TX
o_tx_valid  out  1  o_tx_data valid; held until accepted
i_tx_ready  in  1  UART TX can accept a byte
o_busy  out  1  high in every state except IDLE
o_drop  out  1  one-cycle pulse when a received byte is discarded

Behaviour:
- Reset (i_rst low, asynchronous): state = IDLE. All outputs are 0: o_en_w, o_en_r, o_add, o_wr_data, o_tx_data, o_tx_valid, o_busy, o_drop. The address and data latches are cleared.
- All outputs are registered.
- IDLE:
  - rx byte == CMD_WR -> WR_ADDR.
  - rx byte == CMD_RD -> RD_ADDR.
  - Any other byte -> stay in IDLE and pulse o_drop.
- WR_ADDR: on rx, latch addr = byte[ADDR_WIDTH-1:0] -> WR_DATA.
- WR_DATA: on rx, latch data -> WR_EXEC.
- WR_EXEC: o_en_w=1, o_add=addr, o_wr_data=data for exactly one cycle -> IDLE.
  - Write latency: the o_en_w pulse is asserted 1 cycle after the data-byte strobe.
- RD_ADDR: on rx, latch addr -> RD_EXEC.
- RD_EXEC: o_en_r=1, o_add=addr for exactly one cycle -> RD_WAIT.
- RD_WAIT: wait for i_rd_valid; capture i_rd_data into o_tx_data -> TX_SEND.
  - i_rd_valid is ignored in every other state.
- TX_SEND: o_tx_valid=1 with o_tx_data stable. Transfer occurs on the cycle where o_tx_valid && i_tx_ready; o_tx_valid falls the next cycle -> IDLE.
- o_add holds its last value between transactions.
- Bytes arriving in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND are discarded with an o_drop pulse. No buffering.
- o_en_w and o_en_r are never high in the same cycle.
- A reset mid-frame aborts the frame with no register-file access. A reset in TX_SEND drops o_tx_valid immediately.
- Back-to-back frames: a new opcode is accepted on the first cycle back in IDLE.

Optional Feature:
Macro SYS_CTRL_TIMEOUT_EN.
- Defined: a counter clears on every accepted byte and counts while in WR_ADDR, WR_DATA or RD_ADDR. If it reaches TIMEOUT_CYCLES-1 with no rx strobe, the FSM returns to IDLE, discards the partial frame and pulses o_drop. No register-file access is made. The counter is held at 0 in all other states.
- Undefined: no counter is instantiated, and a partial frame waits indefinitely.

Test Plan:
- Reset: assert i_rst=0 mid-WR_DATA -> all outputs 0, state IDLE, and no o_en_w pulse after release.
- Write frame AA,13,5C -> exactly one o_en_w pulse with o_add=3 (truncated from 0x13) and o_wr_data=5C, 1 cycle after the data strobe.
- Read frame BB,03 with i_rd_valid returned 1 cycle after o_en_r (data 5C), and i_tx_ready held low for 5 cycles -> o_tx_valid stays high with o_tx_data=5C until ready; a single transfer; then IDLE.
- Garbage and overlap: byte 7E in IDLE -> o_drop pulse, no access. Byte 11 sent during TX_SEND -> o_drop pulse and the response is unchanged.
- Back-to-back AA,00,01 then AA,0F,FF with no gap -> two write pulses: (0,01) then (F,FF).
- With SYS_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16: send AA,02, then idle 16 cycles -> o_drop pulse and IDLE. A following BB,02 performs a normal read.
